// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and owner IDs.
// Latency: n/a.  Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port read-return register: captures dmem read data at the end of a granted read.
// Latency: 1 cycle after the grant.  Backpressure: none; the requester must accept rvalid.
module dmem_arb_resp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          capture,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= capture;
      if (capture) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter (core = port 0, loader = port 1) in front of one dmem port.
// Latency: grant same cycle as req, read data 1 cycle later.  Backpressure: req held until gnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_t    state;
  logic          last_owner;
  logic [BW-1:0] burst_cnt;
  logic          gnt0;
  logic          gnt1;

  // Grants are forced low during reset so an in-flight write never reaches dmem.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (state)
        ST_OWN0: begin
          if (m0_req && (!m1_req || burst_cnt < BURST_MAX)) gnt0 = 1'b1;
          else if (m1_req)                                 gnt1 = 1'b1;
        end
        ST_OWN1: begin
          if (m1_req && (!m0_req || burst_cnt < BURST_MAX)) gnt1 = 1'b1;
          else if (m0_req)                                 gnt0 = 1'b1;
        end
        default: begin
          if (m0_req && m1_req) begin
            if (last_owner == OWNER_M1) gnt0 = 1'b1;
            else                        gnt1 = 1'b1;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= OWNER_M1;
      burst_cnt  <= '0;
    end else if (gnt0 || gnt1) begin
      last_owner <= gnt1 ? OWNER_M1 : OWNER_M0;
      state      <= gnt1 ? ST_OWN1 : ST_OWN0;
      // A continuing owner extends its run; any hand-over restarts the run at one.
      if ((gnt0 && state == ST_OWN0) || (gnt1 && state == ST_OWN1))
        burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
      else
        burst_cnt <= BW'(1);
    end else begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  dmem_arb_resp #(.DW(DW)) u_resp0 (
    .clk       (clk),
    .reset     (reset),
    .capture   (gnt0 & ~m0_we),
    .mem_rdata (mem_rdata),
    .rdata     (m0_rdata),
    .rvalid    (m0_rvalid)
  );

  dmem_arb_resp #(.DW(DW)) u_resp1 (
    .clk       (clk),
    .reset     (reset),
    .capture   (gnt1 & ~m1_we),
    .mem_rdata (mem_rdata),
    .rdata     (m1_rdata),
    .rvalid    (m1_rvalid)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (who is granted, shadow memory, expected read returns).
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // requester drive state, indexed by port
  logic          rq [2];
  logic          we [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  // dmem model: combinational read, clocked write
  logic [DW-1:0] dmem [64];
  logic          mem_ready = 1'b0;

  // reference model state
  logic [DW-1:0] ref_mem [64];
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  int            cur, run, last, last_g, obs_g;
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  assign m0_req = rq[0]; assign m0_we = we[0]; assign m0_addr = ad[0]; assign m0_wdata = wd[0];
  assign m1_req = rq[1]; assign m1_we = we[1]; assign m1_addr = ad[1]; assign m1_wdata = wd[1];
  assign mem_rdata = dmem[mem_addr[7:2]];

  function automatic logic [DW-1:0] init_val(input int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Who should own the port this cycle: a lone requester always wins; under
  // contention the current owner keeps it for up to MB grants, otherwise alternate.
  function automatic int pick();
    if (rq[0] && rq[1]) begin
      if (cur < 0) return 1 - last;
      if (run < MB) return cur;
      return 1 - cur;
    end
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  // Called at the falling edge with inputs driven; checks, advances the model, ends at the next falling edge.
  task automatic cycle();
    int g;
    #1;
    g = -1;
    if (!reset) begin
      cur = -1; run = 0; last = 1;
      exp_rv = '{1'b0, 1'b0};
      exp_rd = '{32'h0, 32'h0};
    end
    check("m0_rvalid", m0_rvalid, exp_rv[0]);
    check("m1_rvalid", m1_rvalid, exp_rv[1]);
    check("m0_rdata", m0_rdata, exp_rd[0]);
    check("m1_rdata", m1_rdata, exp_rd[1]);
    if (reset) g = pick();
    obs_g = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
    check("m0_gnt", m0_gnt, g == 0);
    check("m1_gnt", m1_gnt, g == 1);
    check("mem_we", mem_we, (g >= 0) ? we[g] : 1'b0);
    check("mem_addr", mem_addr, (g >= 0) ? ad[g] : '0);
    check("mem_wdata", mem_wdata, (g >= 0) ? wd[g] : '0);
    exp_rv = '{1'b0, 1'b0};
    if (g >= 0) begin
      run  = (g == cur) ? ((run < MB) ? run + 1 : run) : 1;
      cur  = g;
      last = g;
      if (we[g]) ref_mem[ad[g][7:2]] = wd[g];
      else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[ad[g][7:2]];
      end
    end else begin
      cur = -1; run = 0;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    rq[p] = r; we[p] = w; ad[p] = a; wd[p] = d;
  endtask

  task automatic next_reqs();
    for (int p = 0; p < 2; p++) begin
      if (!rq[p] || last_g == p)
        set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)) << 2, $urandom);
    end
  endtask

  initial begin
    logic [DW-1:0] old;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    cur = -1; run = 0; last = 1; last_g = -1; obs_g = -1;
    exp_rv = '{1'b0, 1'b0};
    exp_rd = '{32'h0, 32'h0};
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);

    // reset held with both requesting, then m0 wins first
    set_port(0, 1'b1, 1'b0, 32'h10, '0);
    set_port(1, 1'b1, 1'b0, 32'h20, '0);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check("first_gnt_m0", obs_g, 0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    cycle();

    // m0 write then read back
    set_port(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    cycle();
    set_port(0, 1'b1, 1'b0, 32'h40, '0);
    cycle();
    check("wr_rd_rvalid", m0_rvalid, 1'b1);
    check("wr_rd_data", m0_rdata, 32'hDEADBEEF);
    set_port(0, 1'b0, 1'b0, '0, '0);
    cycle();

    // continuous contention: runs of MB grants alternating with no gap
    begin
      int first;
      set_port(0, 1'b1, 1'b0, 32'h10, '0);
      set_port(1, 1'b1, 1'b0, 32'h20, '0);
      first = -1;
      for (int i = 0; i < 24; i++) begin
        cycle();
        if (i == 0) first = obs_g;
        check("burst_pat", obs_g, first ^ ((i / MB) & 1));
      end
    end

    // m1 alone streams 10 reads
    set_port(0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      set_port(1, 1'b1, 1'b0, 32'(i) << 2, '0);
      cycle();
      check("m1_stream_gnt", obs_g, 1);
      check("m1_stream_rv", m1_rvalid, 1'b1);
      check("m1_stream_rd", m1_rdata, ref_mem[i]);
    end
    set_port(1, 1'b0, 1'b0, '0, '0);
    cycle();

    // reset asserted during a granted write
    old = ref_mem[32];
    set_port(0, 1'b1, 1'b1, 32'h80, ~old);
    #1 check("pre_rst_gnt", m0_gnt, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("rst_gnt", m0_gnt, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rvalid", m0_rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, '0, '0);
    cycle();
    reset = 1'b1;
    cycle();
    check("rst_no_write", dmem[32], old);
    set_port(0, 1'b1, 1'b0, 32'h80, '0);
    set_port(1, 1'b1, 1'b0, 32'h84, '0);
    cycle();
    check("post_rst_first", obs_g, 0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    cycle();

    // m0 owns for two grants, then m1 arrives: m0 finishes its run of MB first
    set_port(0, 1'b1, 1'b0, 32'h8, '0);
    repeat (2) cycle();
    set_port(1, 1'b1, 1'b0, 32'hC, '0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("burst_hold", obs_g, (k < 2) ? 0 : 1);
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      next_reqs();
      cycle();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters.
- Port 0 is the RISC-V core load/store path; port 1 is the debug/loader (DMA) path.
- Sits between the core, the loader and dmem in the top level; dmem keeps its combinational read and clocked write.
- Round-robin on contention, bounded burst ownership, registered read-return per port.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 4, max consecutive grants to one owner while the other port is requesting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 access request; held until m0_gnt.
- m0_we  in  1  port 0 write enable, 1=write, 0=read.
- m0_addr  in  AW  port 0 byte address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  port 0 access issued this cycle (combinational).
- m0_rdata  out  DW  port 0 registered read data.
- m0_rvalid  out  1  port 0 read data valid, 1-cycle pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as port 0, for port 1.
- mem_we  out  1  to dmem write enable.
- mem_addr  out  AW  to dmem address.
- mem_wdata  out  DW  to dmem write data.
- mem_rdata  in  DW  from dmem combinational read data.

Behaviour:
- Reset (reset low, async):
  - state=IDLE, last_owner=1, burst_cnt=0.
  - m0/m1_rvalid=0, m0/m1_rdata=0.
  - m0_gnt=m1_gnt=0 and mem_we=0 for as long as reset is low.
- FSM states: IDLE, OWN0, OWN1. Grant is combinational from the current state and both req inputs; state, last_owner and burst_cnt update on the clock edge.
- IDLE:
  - Single requester: granted in the same cycle.
  - Both requesting: grant the port != last_owner. After reset port 0 wins first.
  - Next state OWNx, burst_cnt=1.
- OWNx:
  - mx_req=1 and (other req=0 or burst_cnt<MAX_BURST): grant x, burst_cnt+1 (saturating at MAX_BURST).
  - Else if other req=1: grant other, next OWN(other), burst_cnt=1, last_owner=other.
  - Else: no grant, next IDLE.
- last_owner updates on every grant.
- At most one gnt is high per cycle. A requester stalls while req=1 and gnt=0.
- Requester rule: addr, we and wdata must be stable while req=1.
- Memory mux when gnt_x=1:
  - mem_addr=mx_addr, mem_wdata=mx_wdata, mem_we=mx_we.
- Memory mux with no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Writes: committed by dmem at the same rising edge that ends the granted cycle. Write latency is 1 edge; no rvalid for writes.
- Reads:
  - At the edge ending a granted read cycle, mx_rdata<=mem_rdata and mx_rvalid<=1 for exactly the next cycle.
  - mx_rdata holds until the next read on that port.
  - Read latency: gnt cycle + 1.
- Back-to-back reads on one port give rvalid high on consecutive cycles, with new data each cycle.
- A switch between ports takes no dead cycle.
- req dropped with no grant (illegal): the request is discarded; no error flag.
- Reset asserted mid-burst: the in-flight cycle's write is suppressed, because mem_we is forced 0 while reset is low. Any pending rvalid is cleared.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding localparams ST_IDLE, ST_OWN0, ST_OWN1;
  - owner IDs OWNER_M0=0, OWNER_M1=1.
- One natural sub-module, dmem_arb_resp: per-port read-capture register (rdata/rvalid). It is instantiated twice.

Test Plan:
- Reset low for 3 cycles with both req=1 -> both gnt=0, mem_we=0, rvalid=0; after release, first grant goes to m0.
- m0 writes 0xDEADBEEF to 0x40, then m0 reads 0x40 -> m0_gnt in the same cycle as each req; m0_rvalid pulses the cycle after the read grant with m0_rdata=0xDEADBEEF.
- m0 and m1 both continuously requesting, MAX_BURST=4 -> gnt pattern m0 x4, m1 x4, m0 x4..., with no idle cycle between owners.
- m1 alone issues 10 consecutive reads of addresses 0x0..0x24 -> 10 grants back-to-back; rvalid high for 10 cycles with matching data.
- m0 write in progress, reset pulled low mid-cycle before the edge -> mem_we=0 immediately and the memory location is unchanged; after release, state=IDLE.
- m0 owns with burst_cnt=2 and m1 idle, then m1 raises req -> m0 keeps grant until burst_cnt=4, then m1 is granted the next cycle.
